vrf_write_arbiter: RTL and testbench
====================================

// Module: vrf_write_arbiter
// PURPOSE
//  Shares one lane VRF write port between NUM_REQ write producers (stage-3 write queues, mask unit, load/store unit).
//  Round-robin grant. Full-throughput 2-entry output buffer, so the VRF-side outputs are registered.
//  Sits between the per-slot stage-3 write queues and the VRF bank write port.
// PARAMETERS
//  NUM_REQ      4   number of requesters (2..8)
//  VD_W         5   vector register index width
//  OFFSET_W     9   VRF offset width
//  DATA_W       32  write data width; mask width = DATA_W/8
//  IDX_W        3   instructionIndex width
// PORTS
//  clock                        in   1                  clock
//  reset                        in   1                  synchronous, active-high
//  req_valid                    in   NUM_REQ            per-requester write valid
//  req_ready                    out  NUM_REQ            per-requester accept
//  req_bits                     in   NUM_REQ x req_t    {vd,offset,mask,data,last,instructionIndex} per requester
//  vrfWriteRequest_ready        in   1                  VRF port accepts
//  vrfWriteRequest_valid        out  1                  buffered write present
//  vrfWriteRequest_bits_*       out  req_t fields       vd/offset/mask/data/last/instructionIndex of buffer head
//  oldestInstructionIndex       in   IDX_W              oldest in-flight instruction (used only with age feature)
//  busy                         out  1                  any req_valid or buffer non-empty
// BEHAVIOUR
//  - Reset: rrPtr=0, buffer count=0, vrfWriteRequest_valid=0, all vrfWriteRequest_bits_*=0, req_ready=0.
//  - Canfill = (count<2), taken from the registered count. req_ready[i] = grant[i] & canFill. At most one req_ready is high.
//  - Grant: the first valid requester scanning rrPtr, rrPtr+1, ... (mod NUM_REQ). No valid requester -> no grant.
//  - On req fire (valid&ready of grant g): rrPtr <= (g+1) mod NUM_REQ. Without a fire, rrPtr holds.
//    Wrap: g = NUM_REQ-1 -> rrPtr=0.
//  - Buffer: 2-entry FIFO, head drives outputs. Latency: request fire in cycle T -> vrfWriteRequest_valid in T+1.
//  - Push+pop in the same cycle: count unchanged. count=2: no grant fires; pops still allowed.
//    count=0: valid low, bits hold their last value (not X).
//  - Sustained: one write per cycle when vrfWriteRequest_ready is held high.
//  - Request bits pass through unmodified (no vd/offset arithmetic here).
//  - Reset asserted mid-operation: buffered entries are dropped and rrPtr returns to 0 on the next edge.
//    Requesters keep their own data.
//  - busy = |req_valid | (count!=0), combinational.
// CONFIGURATION
//  VRF_WRITE_ARB_AGE_EN defined:
//    age_i = (req_bits[i].instructionIndex - oldestInstructionIndex) mod 2^IDX_W.
//    Grant goes to the valid requester with the minimum age; ties are broken by the round-robin scan from rrPtr.
//    rrPtr update is unchanged.
//  Not defined: pure round-robin; oldestInstructionIndex is ignored (port kept, unused).
// STRUCTURE
//  Package vrf_write_arb_pkg:
//    req_t packed struct {vd, offset, mask, data, last, instructionIndex} (54 bits at defaults);
//    localparam REQ_W; function rr_pick(valid, ptr).
//  Sub-module vrf_write_skid: 2-entry registered buffer, req_t in/out, valid/ready both sides.
//  Top: arbiter logic + rrPtr + optional age compare + skid instance.
// TESTING
//  1. Reset; req_valid=4'b0000 -> vrfWriteRequest_valid=0, req_ready=0, busy=0, all bits 0.
//  2. req_valid=4'b1111 held, VRF ready=1 -> grants 0,1,2,3,0 on consecutive cycles; outputs follow one cycle later.
//  3. Single req 2 (vd=3, offset=9'h1A5, data=32'hDEADBEEF, mask=4'hF), VRF ready=0 -> fires once.
//     Head holds those bits with valid=1 until ready is raised; a second beat fills count=2, then req_ready=0.
//  4. count=2, VRF ready=1, req 1 valid -> same cycle: pop and no push; next cycle push; no beat lost or duplicated.
//  5. Reset asserted with count=2 -> next cycle valid=0, rrPtr=0; after release, req 3 alone is granted.
//  6. AGE_EN: oldest=6, req0 idx=1, req2 idx=7, rrPtr=0 -> req2 granted (age 1 < age 3).
//     Without the macro, req0 is granted.

Source files
------------

// File: rtl/vrf_write_arb_pkg.sv
// Shared types and helpers for the VRF write-port arbiter.
//   req_t    : one VRF write beat {vd, offset, mask, data, last, instructionIndex}
//   REQ_W    : packed width of req_t (54 bits at the default field widths)
//   rr_pick  : one-hot round-robin pick over up to MAX_REQ requesters
package vrf_write_arb_pkg;

  localparam int VD_W     = 5;
  localparam int OFFSET_W = 9;
  localparam int DATA_W   = 32;
  localparam int MASK_W   = DATA_W / 8;
  localparam int IDX_W    = 3;
  localparam int MAX_REQ  = 8;

  typedef struct packed {
    logic [VD_W-1:0]     vd;
    logic [OFFSET_W-1:0] offset;
    logic [MASK_W-1:0]   mask;
    logic [DATA_W-1:0]   data;
    logic                last;
    logic [IDX_W-1:0]    instructionIndex;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  // First set bit of valid scanning ptr, ptr+1, ... modulo n (n <= MAX_REQ).
  // Bits at or above n are never set in the result.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [2:0]         ptr,
                                                 input int                 n);
    logic [MAX_REQ-1:0] g;
    logic               found;
    int                 idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (!found && valid[idx[2:0]]) begin
          g[idx[2:0]] = 1'b1;
          found       = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/vrf_write_skid.sv
// Two-entry registered buffer between the arbiter and the VRF write port.
// The head register drives the outputs directly, so the VRF side sees only
// flops. Accepts whenever fewer than two entries are held (full throughput:
// a push and a pop may happen in the same cycle).
// Ports:
//   clock, reset      clock, synchronous active-high reset
//   in_valid_i/in_ready_o/in_bits_i    producer side handshake + beat
//   out_valid_o/out_ready_i/out_bits_o VRF side handshake + head beat
//   count_o           occupancy (0..2), registered
module vrf_write_skid
  import vrf_write_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  req_t       in_bits_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output req_t       out_bits_o,
  output logic [1:0] count_o
);

  req_t       head_q, head_d;
  req_t       tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_bits_o  = head_q;
  assign count_o     = count_q;

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  // With an empty buffer the head keeps the last beat that left it, so the
  // output bits never go unknown.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      if (count_q == 2'd2) begin
        head_d = tail_q;
        if (push) tail_d = in_bits_i;
      end else if (push) begin
        head_d = in_bits_i;
      end
    end else if (push) begin
      if (count_q == 2'd0) head_d = in_bits_i;
      else                 tail_d = in_bits_i;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vrf_write_arbiter.sv
// Shares one lane VRF write port between NUM_REQ write producers (stage-3
// write queues, mask unit, load/store unit). Round-robin grant feeding a
// two-entry registered buffer; a beat accepted in cycle T is presented to
// the VRF in T+1, and one beat per cycle is sustained.
// Optional build macro VRF_WRITE_ARB_AGE_EN: grant goes to the valid
// requester whose instructionIndex is closest to oldestInstructionIndex
// (modular distance), ties resolved by the round-robin scan. Without it,
// oldestInstructionIndex is unused.
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   req_valid/req_ready/req_bits per-requester handshake + beat
//   vrfWriteRequest_*            VRF write port (registered head of buffer)
//   oldestInstructionIndex       oldest in-flight instruction (age mode)
//   busy                         any requester valid or buffer non-empty
module vrf_write_arbiter
  import vrf_write_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  req_t [NUM_REQ-1:0]       req_bits,
  input  logic                     vrfWriteRequest_ready,
  output logic                     vrfWriteRequest_valid,
  output logic [VD_W-1:0]          vrfWriteRequest_bits_vd,
  output logic [OFFSET_W-1:0]      vrfWriteRequest_bits_offset,
  output logic [MASK_W-1:0]        vrfWriteRequest_bits_mask,
  output logic [DATA_W-1:0]        vrfWriteRequest_bits_data,
  output logic                     vrfWriteRequest_bits_last,
  output logic [IDX_W-1:0]         vrfWriteRequest_bits_instructionIndex,
  input  logic [IDX_W-1:0]         oldestInstructionIndex,
  output logic                     busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rrPtr_q, rrPtr_d;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [MAX_REQ-1:0] elig_ext;
  logic [MAX_REQ-1:0] pick;
  logic [PTR_W-1:0]   gidx;
  req_t               sel_bits;
  req_t               head;
  logic               canFill;
  logic               fire;
  logic [1:0]         count;
  logic               unused_sink;

`ifdef VRF_WRITE_ARB_AGE_EN
  logic [NUM_REQ-1:0][IDX_W-1:0] age;
  logic [IDX_W-1:0]              min_age;

  // Age wraps modulo 2^IDX_W, so the subtraction is kept at IDX_W bits.
  always_comb begin
    age     = '0;
    min_age = '1;
    elig    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      age[i] = req_bits[i].instructionIndex - oldestInstructionIndex;
      if (req_valid[i] && (age[i] < min_age)) min_age = age[i];
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && (age[i] == min_age);
    end
  end

  assign unused_sink = ^pick;
`else
  assign elig        = req_valid;
  assign unused_sink = ^{pick, oldestInstructionIndex};
`endif

  always_comb begin
    elig_ext              = '0;
    elig_ext[NUM_REQ-1:0] = elig;
    pick                  = rr_pick(elig_ext, 3'(rrPtr_q), NUM_REQ);
    grant                 = pick[NUM_REQ-1:0];
  end

  always_comb begin
    sel_bits = '0;
    gidx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_bits = req_bits[i];
        gidx     = PTR_W'(i);
      end
    end
  end

  // canFill comes from the registered occupancy, so req_ready has no path
  // from vrfWriteRequest_ready.
  assign req_ready = grant & {NUM_REQ{canFill}};
  assign fire      = |req_ready;

  always_comb begin
    rrPtr_d = rrPtr_q;
    if (fire) begin
      rrPtr_d = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) rrPtr_q <= '0;
    else       rrPtr_q <= rrPtr_d;
  end

  vrf_write_skid u_skid (
    .clock       (clock),
    .reset       (reset),
    .in_valid_i  (|grant),
    .in_ready_o  (canFill),
    .in_bits_i   (sel_bits),
    .out_valid_o (vrfWriteRequest_valid),
    .out_ready_i (vrfWriteRequest_ready),
    .out_bits_o  (head),
    .count_o     (count)
  );

  assign vrfWriteRequest_bits_vd               = head.vd;
  assign vrfWriteRequest_bits_offset           = head.offset;
  assign vrfWriteRequest_bits_mask             = head.mask;
  assign vrfWriteRequest_bits_data             = head.data;
  assign vrfWriteRequest_bits_last             = head.last;
  assign vrfWriteRequest_bits_instructionIndex = head.instructionIndex;

  assign busy = (|req_valid) | (count != 2'd0);

endmodule

// File: tb/tb_vrf_write_arbiter.sv
module tb_vrf_write_arbiter;
  import vrf_write_arb_pkg::*;

  localparam int N = 4;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [N-1:0]        req_valid = '0;
  logic [N-1:0]        req_ready;
  req_t [N-1:0]        req_bits = '0;
  logic                vrf_ready = 1'b0;
  logic                vrf_valid;
  logic [VD_W-1:0]     o_vd;
  logic [OFFSET_W-1:0] o_offset;
  logic [MASK_W-1:0]   o_mask;
  logic [DATA_W-1:0]   o_data;
  logic                o_last;
  logic [IDX_W-1:0]    o_idx;
  logic [IDX_W-1:0]    oldest = '0;
  logic                busy;

  int tests = 0;
  int fails = 0;
  req_t sb[$];

  vrf_write_arbiter #(.NUM_REQ(N)) dut (
    .clock                                 (clock),
    .reset                                 (reset),
    .req_valid                             (req_valid),
    .req_ready                             (req_ready),
    .req_bits                              (req_bits),
    .vrfWriteRequest_ready                 (vrf_ready),
    .vrfWriteRequest_valid                 (vrf_valid),
    .vrfWriteRequest_bits_vd               (o_vd),
    .vrfWriteRequest_bits_offset           (o_offset),
    .vrfWriteRequest_bits_mask             (o_mask),
    .vrfWriteRequest_bits_data             (o_data),
    .vrfWriteRequest_bits_last             (o_last),
    .vrfWriteRequest_bits_instructionIndex (o_idx),
    .oldestInstructionIndex                (oldest),
    .busy                                  (busy)
  );

  always #5 clock = ~clock;

  function automatic req_t mk(input int tag);
    req_t r;
    r.vd               = 5'(tag);
    r.offset           = 9'(tag * 7 + 3);
    r.mask             = 4'(tag);
    r.data             = 32'hC0DE_0000 | 32'(tag);
    r.last             = tag[0];
    r.instructionIndex = 3'(tag);
    return r;
  endfunction

  function automatic req_t head_now();
    req_t r;
    r = '{vd: o_vd, offset: o_offset, mask: o_mask, data: o_data,
          last: o_last, instructionIndex: o_idx};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every accepted VRF beat must match the next expected one.
  always @(negedge clock) begin
    if (!reset && vrf_valid && vrf_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got %h expected none", head_now());
      end else begin
        req_t e;
        e = sb.pop_front();
        chk("vrf_beat", 64'(head_now()), 64'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    req_t a, b, c, d, e, f, g, h, k, exp_age;

    // 1. Reset state
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_valid", 64'(vrf_valid), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_bits", 64'(head_now()), 64'd0);

    // 2. All requesters valid, VRF ready: grants 0,1,2,3,0
    for (int i = 0; i < N; i++) req_bits[i] = mk(i + 1);
    req_valid = 4'b1111;
    vrf_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (cyc % 4)));
      chk("rr_out_valid", 64'(vrf_valid), 64'(cyc != 0));
      sb.push_back(mk((cyc % 4) + 1));
      step();
    end
    req_valid = '0;
    drain();
    #1;
    chk("idle_busy", 64'(busy), 64'd0);

    // 3. Single requester 2, VRF stalled; fill to two entries
    a = '{vd: 5'd3, offset: 9'h1A5, mask: 4'hF, data: 32'hDEADBEEF, last: 1'b1, instructionIndex: 3'd2};
    b = mk(20);
    c = mk(21);
    vrf_ready   = 1'b0;
    req_bits[2] = a;
    req_valid   = 4'b0100;
    #1;
    chk("s3_grant2", 64'(req_ready), 64'(4'b0100));
    sb.push_back(a);
    step();
    req_bits[2] = b;
    #1;
    chk("s3_valid_T1", 64'(vrf_valid), 64'd1);
    chk("s3_head_a", 64'(head_now()), 64'(a));
    chk("s3_grant2_again", 64'(req_ready), 64'(4'b0100));
    sb.push_back(b);
    step();
    req_bits[2] = c;
    #1;
    chk("s3_full_noready", 64'(req_ready), 64'd0);
    chk("s3_busy", 64'(busy), 64'd1);
    step(); step();
    chk("s3_hold_valid", 64'(vrf_valid), 64'd1);
    chk("s3_hold_head", 64'(head_now()), 64'(a));

    // 4. Full buffer, VRF ready, requester 1: pop first, push next cycle
    d = mk(22);
    req_valid   = 4'b0010;
    req_bits[1] = d;
    vrf_ready   = 1'b1;
    #1;
    chk("s4_full_no_push", 64'(req_ready), 64'd0);
    step();
    #1;
    chk("s4_push_next", 64'(req_ready), 64'(4'b0010));
    chk("s4_head_b", 64'(head_now()), 64'(b));
    sb.push_back(d);
    step();
    req_valid = '0;
    drain();

    // 5. Reset with two entries held
    e = mk(23);
    f = mk(24);
    g = mk(25);
    vrf_ready   = 1'b0;
    req_bits[0] = e;
    req_valid   = 4'b0001;
    #1;
    chk("s5_grant0", 64'(req_ready), 64'(4'b0001));
    step();
    req_bits[0] = f;
    #1;
    chk("s5_grant0_wrap", 64'(req_ready), 64'(4'b0001));
    step();
    #1;
    chk("s5_full", 64'(req_ready), 64'd0);
    reset     = 1'b1;
    req_valid = '0;
    step();
    #1;
    chk("s5_rst_valid", 64'(vrf_valid), 64'd0);
    chk("s5_rst_busy", 64'(busy), 64'd0);
    chk("s5_rst_bits", 64'(head_now()), 64'd0);
    reset       = 1'b0;
    req_bits[3] = g;
    req_valid   = 4'b1001;
    #1;
    chk("s5_ptr_zero", 64'(req_ready), 64'(4'b0001));
    req_valid = 4'b1000;
    vrf_ready = 1'b1;
    #1;
    chk("s5_grant3", 64'(req_ready), 64'(4'b1000));
    sb.push_back(g);
    step();
    req_valid = '0;
    drain();

    // 6. Age compare: oldest=6, req0 idx=1 (age 3), req2 idx=7 (age 1)
    h = mk(26);
    h.instructionIndex = 3'd1;
    k = mk(27);
    k.instructionIndex = 3'd7;
    oldest      = 3'd6;
    req_bits[0] = h;
    req_bits[2] = k;
    req_valid   = 4'b0101;
    #1;
`ifdef VRF_WRITE_ARB_AGE_EN
    chk("s6_age_grant", 64'(req_ready), 64'(4'b0100));
    exp_age = k;
`else
    chk("s6_rr_grant", 64'(req_ready), 64'(4'b0001));
    exp_age = h;
`endif
    sb.push_back(exp_age);
    step();
    req_valid = '0;
    drain();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
